// File: rtl/activation_skew_feeder_if.sv
// Activation feeder bus: column-beat input handshake plus the skewed row
// outputs that drive the west edge of the systolic array.
interface activation_skew_feeder_if #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
) ();
    logic                               in_valid;
    logic                               in_ready;
    logic [MATRIX_SIZE*DATA_SIZE-1:0]   in_data;
    logic [MATRIX_SIZE*DATA_SIZE-1:0]   a_out;
    logic [MATRIX_SIZE-1:0]             a_valid;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  a_out,
        input  a_valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output a_out,
        output a_valid
    );
endinterface

// File: rtl/activation_skew_feeder.sv
// Buffers one NxN activation matrix column by column and streams it into the
// systolic array with row r delayed by r steps, each step held STEP_CYCLES.
//
// state | meaning
// LOAD  | accepting column beats, in_ready high, start may be latched
// ARMED | matrix buffered, waiting for the weights-loaded start pulse
// FEED  | driving skewed rows, busy high
// DONE  | one-cycle done pulse, then back to LOAD
module activation_skew_feeder #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int STEP_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_enable,
    input  logic                     i_start,
    activation_skew_feeder_if.slave  bus,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int N      = MATRIX_SIZE;
    localparam int DW     = DATA_SIZE;
    localparam int COL_W  = $clog2(N + 1);
    localparam int STEP_W = $clog2(2 * N);
    localparam int SUB_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int IDX_W  = $clog2(N);

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(N - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * N - 2);
    localparam logic [SUB_W-1:0]  LAST_SUB  = SUB_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_ARMED,
        S_FEED,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [COL_W-1:0]    r_col_cnt;
    logic                r_start_pending;
    logic [STEP_W-1:0]   r_step;
    logic [SUB_W-1:0]    r_sub;
    logic                r_in_ready;
    logic [N*DW-1:0]     r_a_out;
    logic [N-1:0]        r_a_valid;
    logic                r_busy;
    logic                r_done;
    logic [DW-1:0]       r_buf [N][N];

    logic                w_accept;
    logic [STEP_W-1:0]   w_sel_step;
    logic [N*DW-1:0]     w_feed_data;
    logic [N-1:0]        w_feed_valid;
    int                  w_diff;

    assign w_accept = i_enable & bus.in_valid & r_in_ready & (r_state == S_LOAD);

    // Row pattern for the step about to be shown: step 0 when entering FEED,
    // otherwise the step following the current one.
    always_comb begin
        w_sel_step   = (r_state == S_FEED) ? r_step + 1'b1 : '0;
        w_feed_data  = '0;
        w_feed_valid = '0;
        w_diff       = 0;
        for (int r = 0; r < N; r++) begin
            w_diff = int'(w_sel_step) - r;
            if (w_diff >= 0 && w_diff < N) begin
                w_feed_valid[r]          = 1'b1;
                w_feed_data[r*DW +: DW]  = r_buf[r][w_diff[IDX_W-1:0]];
            end
        end
    end

    // Matrix storage: beat k lands in column k; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 0; r < N; r++) begin
                r_buf[r][r_col_cnt[IDX_W-1:0]] <= bus.in_data[r*DW +: DW];
            end
        end
    end

    // Sequencer FSM with registered outputs; enable low freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_LOAD;
            r_col_cnt       <= '0;
            r_start_pending <= 1'b0;
            r_step          <= '0;
            r_sub           <= '0;
            r_in_ready      <= 1'b1;
            r_a_out         <= '0;
            r_a_valid       <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else if (i_enable) begin
            case (r_state)
                S_LOAD: begin
                    if (i_start) begin
                        r_start_pending <= 1'b1;
                    end
                    if (w_accept) begin
                        r_col_cnt <= r_col_cnt + 1'b1;
                        if (r_col_cnt == LAST_COL) begin
                            r_col_cnt       <= '0;
                            r_start_pending <= 1'b0;
                            r_in_ready      <= 1'b0;
                            if (r_start_pending || i_start) begin
                                r_state   <= S_FEED;
                                r_busy    <= 1'b1;
                                r_step    <= '0;
                                r_sub     <= '0;
                                r_a_out   <= w_feed_data;
                                r_a_valid <= w_feed_valid;
                            end else begin
                                r_state <= S_ARMED;
                            end
                        end
                    end
                end
                S_ARMED: begin
                    if (i_start) begin
                        r_state   <= S_FEED;
                        r_busy    <= 1'b1;
                        r_step    <= '0;
                        r_sub     <= '0;
                        r_a_out   <= w_feed_data;
                        r_a_valid <= w_feed_valid;
                    end
                end
                S_FEED: begin
                    if (r_sub == LAST_SUB) begin
                        r_sub <= '0;
                        if (r_step == LAST_STEP) begin
                            r_state   <= S_DONE;
                            r_step    <= '0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_a_out   <= '0;
                            r_a_valid <= '0;
                        end else begin
                            r_step    <= r_step + 1'b1;
                            r_a_out   <= w_feed_data;
                            r_a_valid <= w_feed_valid;
                        end
                    end else begin
                        r_sub <= r_sub + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state         <= S_LOAD;
                    r_done          <= 1'b0;
                    r_in_ready      <= 1'b1;
                    r_col_cnt       <= '0;
                    r_start_pending <= 1'b0;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.a_out    = r_a_out;
    assign bus.a_valid  = r_a_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
endmodule

// File: tb/tb_activation_skew_feeder.sv
// Bench for activation_skew_feeder: an N=2/STEP_CYCLES=4 instance for the
// feed scenarios and an N=3/STEP_CYCLES=2 instance for the handshake stall.
module tb_activation_skew_feeder;
    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic start2, start3;
    logic busy2, done2, busy3, done3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0]  v;
        logic [95:0] d;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t q[$];

    activation_skew_feeder_if #(.MATRIX_SIZE(2), .DATA_SIZE(32)) bus2 ();
    activation_skew_feeder_if #(.MATRIX_SIZE(3), .DATA_SIZE(32)) bus3 ();

    activation_skew_feeder #(.MATRIX_SIZE(2), .DATA_SIZE(32), .STEP_CYCLES(4)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .i_enable (enable),
        .i_start  (start2),
        .bus      (bus2.slave),
        .o_busy   (busy2),
        .o_done   (done2)
    );

    activation_skew_feeder #(.MATRIX_SIZE(3), .DATA_SIZE(32), .STEP_CYCLES(2)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .i_enable (enable),
        .i_start  (start3),
        .bus      (bus3.slave),
        .o_busy   (busy3),
        .o_done   (done3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model: one entry per cycle of FEED, then the done cycle.
    task automatic push_expected(input int n, input int sc, input logic [95:0] c0,
                                 input logic [95:0] c1, input logic [95:0] c2,
                                 input int hold_step, input int hold_extra);
        logic [95:0] cols [3];
        exp_t e;
        int cyc;
        int d;
        cols[0] = c0;
        cols[1] = c1;
        cols[2] = c2;
        for (int s = 0; s <= 2 * n - 2; s++) begin
            cyc = sc + ((s == hold_step) ? hold_extra : 0);
            for (int c = 0; c < cyc; c++) begin
                e = '0;
                for (int r = 0; r < n; r++) begin
                    d = s - r;
                    if (d >= 0 && d < n) begin
                        e.v[r]         = 1'b1;
                        e.d[r*32 +: 32] = cols[d][r*32 +: 32];
                    end
                end
                e.busy = 1'b1;
                q.push_back(e);
            end
        end
        e = '0;
        e.done = 1'b1;
        q.push_back(e);
    endtask

    // Two beats into the N=2 instance; caller is at a negedge with in_ready high.
    task automatic load2(input logic [63:0] b0, input logic [63:0] b1);
        bus2.in_valid = 1'b1;
        bus2.in_data  = b0;
        @(negedge clk);
        bus2.in_data  = b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        start2 = 1'b0;
        start3 = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.in_data = '0;
        bus3.in_valid = 1'b0;
        bus3.in_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus2.in_ready, bus2.a_valid, busy2, done2} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl2: got %b, expected 10000", {bus2.in_ready, bus2.a_valid, busy2, done2});
        end
        n_checks++;
        if (bus2.a_out !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_aout2: got %h, expected 0", bus2.a_out);
        end
        n_checks++;
        if ({bus3.in_ready, bus3.a_valid, busy3, done3, bus3.a_out} !== {1'b1, 3'b000, 2'b00, 96'd0}) begin
            n_fail++;
            $display("FAIL reset_dut3: got rdy=%b v=%b busy=%b done=%b, expected rdy=1 v=000 busy=0 done=0",
                     bus3.in_ready, bus3.a_valid, busy3, done3);
        end
    endtask

    task automatic drain2(input string name, input int freeze_at, input int thaw_at);
        exp_t e;
        int total;
        total = q.size();
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            bus2.in_valid = 1'b0;
            e = q.pop_front();
            n_checks++;
            if ({bus2.a_valid, bus2.a_out, busy2, done2} !== {e.v[1:0], e.d[63:0], e.busy, e.done}) begin
                n_fail++;
                $display("FAIL %s cyc%0d: got v=%b d=%h busy=%b done=%b, expected v=%b d=%h busy=%b done=%b",
                         name, k, bus2.a_valid, bus2.a_out, busy2, done2, e.v[1:0], e.d[63:0], e.busy, e.done);
            end
            if (k == freeze_at) enable = 1'b0;
            if (k == thaw_at)   enable = 1'b1;
        end
    endtask

    task automatic test_basic_feed();
        load2({32'd3, 32'd1}, {32'd4, 32'd2});
        n_checks++;
        if (bus2.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_armed_ready: got %b, expected 0", bus2.in_ready);
        end
        start2 = 1'b1;
        push_expected(2, 4, {32'd0, 32'd3, 32'd1}, {32'd0, 32'd4, 32'd2}, '0, -1, 0);
        drain2("basic_feed", -1, -1);
        @(negedge clk);
        n_checks++;
        if (bus2.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready_after_done: got %b, expected 1", bus2.in_ready);
        end
    endtask

    task automatic test_early_start();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        bus2.in_valid = 1'b1;
        bus2.in_data = {32'd11, 32'd9};
        @(negedge clk);
        bus2.in_data = {32'd12, 32'd10};
        push_expected(2, 4, {32'd0, 32'd11, 32'd9}, {32'd0, 32'd12, 32'd10}, '0, -1, 0);
        drain2("early_start", -1, -1);
        @(negedge clk);
    endtask

    task automatic test_enable_freeze();
        load2({32'd3, 32'd1}, {32'd4, 32'd2});
        start2 = 1'b1;
        push_expected(2, 4, {32'd0, 32'd3, 32'd1}, {32'd0, 32'd4, 32'd2}, '0, 1, 5);
        drain2("enable_freeze", 5, 10);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_feed();
        exp_t e;
        load2({32'd3, 32'd1}, {32'd4, 32'd2});
        start2 = 1'b1;
        push_expected(2, 4, {32'd0, 32'd3, 32'd1}, {32'd0, 32'd4, 32'd2}, '0, -1, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            e = q.pop_front();
            n_checks++;
            if ({bus2.a_valid, bus2.a_out, busy2} !== {e.v[1:0], e.d[63:0], e.busy}) begin
                n_fail++;
                $display("FAIL pre_reset cyc%0d: got v=%b d=%h busy=%b, expected v=%b d=%h busy=%b",
                         k, bus2.a_valid, bus2.a_out, busy2, e.v[1:0], e.d[63:0], e.busy);
            end
        end
        q.delete();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus2.in_ready, bus2.a_valid, busy2, done2, bus2.a_out} !== {1'b1, 2'b00, 2'b00, 64'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b v=%b busy=%b done=%b d=%h, expected rdy=1 v=00 busy=0 done=0 d=0",
                     bus2.in_ready, bus2.a_valid, busy2, done2, bus2.a_out);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({done2, busy2, bus2.in_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL no_done_after_reset cyc%0d: got done/busy/rdy=%b, expected 001",
                         k, {done2, busy2, bus2.in_ready});
            end
        end
        load2({32'd3, 32'd1}, {32'd4, 32'd2});
        start2 = 1'b1;
        push_expected(2, 4, {32'd0, 32'd3, 32'd1}, {32'd0, 32'd4, 32'd2}, '0, -1, 0);
        drain2("refeed_after_reset", -1, -1);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        load2({32'd3, 32'd1}, {32'd4, 32'd2});
        start2 = 1'b1;
        push_expected(2, 4, {32'd0, 32'd3, 32'd1}, {32'd0, 32'd4, 32'd2}, '0, -1, 0);
        drain2("b2b_first", -1, -1);
        @(negedge clk);
        n_checks++;
        if (bus2.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b, expected 1", bus2.in_ready);
        end
        load2({32'd7, 32'd5}, {32'd8, 32'd6});
        start2 = 1'b1;
        push_expected(2, 4, {32'd0, 32'd7, 32'd5}, {32'd0, 32'd8, 32'd6}, '0, -1, 0);
        drain2("b2b_second", -1, -1);
        @(negedge clk);
    endtask

    task automatic test_handshake_stall();
        exp_t e;
        int total;
        logic [95:0] c0, c1, c2;
        c0 = {32'd31, 32'd21, 32'd11};
        c1 = {32'd32, 32'd22, 32'd12};
        c2 = {32'd33, 32'd23, 32'd13};
        bus3.in_valid = 1'b1;
        bus3.in_data = c0;
        @(negedge clk);
        bus3.in_valid = 1'b0;
        bus3.in_data = 96'hBAD;
        @(negedge clk);
        n_checks++;
        if (bus3.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_ready_mid: got %b, expected 1", bus3.in_ready);
        end
        bus3.in_valid = 1'b1;
        bus3.in_data = c1;
        @(negedge clk);
        bus3.in_valid = 1'b0;
        @(negedge clk);
        bus3.in_valid = 1'b1;
        bus3.in_data = c2;
        @(negedge clk);
        bus3.in_data = {32'hDEAD, 32'hBEEF, 32'hF00D};
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus3.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_armed_ready cyc%0d: got %b, expected 0", k, bus3.in_ready);
            end
            @(negedge clk);
        end
        bus3.in_valid = 1'b0;
        start3 = 1'b1;
        push_expected(3, 2, c0, c1, c2, -1, 0);
        total = q.size();
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            start3 = 1'b0;
            e = q.pop_front();
            n_checks++;
            if ({bus3.a_valid, bus3.a_out, busy3, done3} !== {e.v, e.d, e.busy, e.done}) begin
                n_fail++;
                $display("FAIL stall_feed cyc%0d: got v=%b d=%h busy=%b done=%b, expected v=%b d=%h busy=%b done=%b",
                         k, bus3.a_valid, bus3.a_out, busy3, done3, e.v, e.d, e.busy, e.done);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_feed();
        test_early_start();
        test_handshake_stall();
        test_enable_freeze();
        test_reset_mid_feed();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/activation_skew_feeder.md
# activation_skew_feeder

Buffers one MATRIX_SIZE×MATRIX_SIZE activation matrix and drives it into the west edge of the systolic array with the diagonal skew the PE grid requires. Row r is delayed by r steps, and each step is held for STEP_CYCLES cycles to match the PE multiply cadence. The block sits directly downstream of the weight-load scheduler: it starts streaming when the scheduler signals that weights are resident. Its (2N−1)·STEP_CYCLES feed window matches the scheduler's multiply window.

## Interface
- MATRIX_SIZE, 2, array dimension N (rows = columns), ≥2
- DATA_SIZE, 32, activation element width in bits
- STEP_CYCLES, 4, cycles each skew step is held, ≥1
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- enable  in  1  global advance; low freezes all state and outputs
- start  in  1  weights-loaded pulse from scheduler; single-cycle, sampled when enable=1
- in_valid  in  1  input column beat valid
- in_ready  out  1  block can accept a column beat
- in_data  in  N·DATA_SIZE  column k of A; bits [r·DATA_SIZE +: DATA_SIZE] = A[r][k]
- a_out  out  N·DATA_SIZE  row r activation at bits [r·DATA_SIZE +: DATA_SIZE]
- a_valid  out  N  per-row activation valid
- busy  out  1  high while in FEED
- done  out  1  one-cycle pulse after the last step completes

## Operation
- States: LOAD, ARMED, FEED, DONE. Reset enters LOAD with col_cnt=0, start_pending=0.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid & in_ready & enable. Accepted beat k is stored as column col_cnt, then col_cnt increments.
  - On acceptance of beat N−1: go to FEED if start_pending or start is high that cycle; otherwise go to ARMED.
- start in LOAD sets start_pending. Multiple pulses collapse into one.
- ARMED: in_ready=0. start → FEED.
- FEED: step s runs 0..2N−2 and sub runs 0..STEP_CYCLES−1. During step s, row r drives:
  - a_out = A[r][s−r] and a_valid[r]=1 when 0 ≤ s−r ≤ N−1;
  - a_out = 0 and a_valid[r]=0 otherwise.
- After the last cycle of step 2N−2: go to DONE. Outputs are cleared to zero.
- DONE: done=1 for one cycle. Then go to LOAD with col_cnt=0 and start_pending=0.
- start in ARMED-exit, FEED, or DONE is ignored and not latched.
- Counters:
  - col_cnt is $clog2(N+1) bits.
  - step is $clog2(2N) bits.
  - sub is max(1, $clog2(STEP_CYCLES)) bits.
  - No wrap-around occurs; counters are reset explicitly on state exit.

## Timing
- Reset values: in_ready=1, a_out=0, a_valid=0, busy=0, done=0. The buffer contents are don't-care.
- All outputs are registered. in_ready is a registered state decode.
- Feed latency:
  - start sampled at edge t in ARMED → a_valid/a_out show step 0 from edge t.
  - Equivalently, the final LOAD beat with start pending at edge t gives the same timing.
- Feed duration: each step is visible for exactly STEP_CYCLES cycles. busy=1 for (2N−1)·STEP_CYCLES cycles.
- done rises on the edge after the last FEED cycle. busy and a_valid fall on that same edge.
- Back-to-back operation: in_ready returns 1 one cycle after done.
- enable=0 freezes everything:
  - state, counters, and outputs hold;
  - no beat is accepted even if in_valid=1;
  - start is ignored;
  - done is held (a frozen done pulse stretches).
- Reset mid-operation clears immediately to reset values, with no done pulse.

## Test plan
- Basic feed, N=2, STEP_CYCLES=4. Load beat0 {A00=1, A10=3} and beat1 {A01=2, A11=4}, then start. Required response:
  - cycles 0–3: row0=1 valid, row1 invalid;
  - cycles 4–7: row0=2, row1=3, both valid;
  - cycles 8–11: row0 invalid, row1=4;
  - cycle 12: done=1, a_valid=00.
- Early start: pulse start before beat0. FEED must begin on the edge accepting beat1, with no ARMED cycle.
- Handshake stall: toggle in_valid 1,0,1 with N=3. Exactly 3 beats are accepted. in_ready drops after beat 2. Extra in_valid beats in ARMED are not consumed.
- Enable freeze: drop enable for 5 cycles mid-step 1. a_out holds 2/3 and step 1 spans 9 cycles total. done still arrives after all 3 steps.
- Reset mid-FEED: assert reset at step 1. Required response:
  - outputs go to 0 asynchronously and in_ready=1;
  - no done pulse;
  - a subsequent full load + start reproduces the basic-feed sequence.
- Back-to-back matrices: a second load of {5,7},{6,8} immediately after done produces 5 / 6,7 / 8 with identical timing.
